// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared constants and state type for the multicycle control unit
//
// Purpose: opcode/funct encodings, ALU control codes, PC/ALU mux selects,
// trap-cause codes and the controller state enum.
// Ports: none (package).
package mc_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct field
  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXECUTE,
    ST_R_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_ADDI_EX,
    ST_ADDI_WB,
    ST_TRAP
  } state_e;

  // States that hold on the memory handshake and are subject to the timeout.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// rtl/alu_funct_decoder.sv - R-type funct to ALU control decoder
//
// Purpose: maps an R-type funct to its ALU control code and flags whether the
// funct is one of the supported operations.
// Ports:
//   funct_i      funct field
//   alu_cntrl_o  ALU control code (NOP code when funct is not supported)
//   valid_o      funct is ADD/SUB/AND/OR/SLT
module alu_funct_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUC_W  = 4
) (
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [ALUC_W-1:0]  alu_cntrl_o,
  output logic               valid_o
);

  always_comb begin
    alu_cntrl_o = ALU_NOP;
    valid_o     = 1'b1;
    case (funct_i)
      FN_ADD:  alu_cntrl_o = ALU_ADD;
      FN_SUB:  alu_cntrl_o = ALU_SUB;
      FN_AND:  alu_cntrl_o = ALU_AND;
      FN_OR:   alu_cntrl_o = ALU_OR;
      FN_SLT:  alu_cntrl_o = ALU_SLT;
      default: valid_o     = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS control FSM with memory handshake
//
// Purpose: sequences the shared-memory multicycle datapath one step per clock,
// with ready-based memory waits, a wait timeout, a sticky trap and a retired
// instruction counter.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   op_in, func_in             opcode/funct from the instruction register
//   mem_ready                  memory access complete
//   mem_read, mem_write,
//   i_or_d, ir_write           memory and IR controls
//   pc_write, pc_write_cond,
//   pc_source                  PC update controls
//   alu_src_a, alu_src_b,
//   alu_cntrl                  ALU operand selects and operation
//   reg_write, reg_dst,
//   mem_to_reg                 register-file controls
//   trap, trap_cause           sticky trap flag and its cause
//   retire, retired_cnt        completion pulse and wrapping counter
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUC_W   = 4,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op_in,
  input  logic [FUNCT_W-1:0] func_in,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUC_W-1:0]  alu_cntrl,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic               retire,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [FUNCT_W-1:0]  func_q;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]          trap_cause_q, trap_cause_d;
  logic                retire_q, retire_d;
  logic [CNT_W-1:0]    retired_cnt_q;

  logic [FUNCT_W-1:0]  dec_funct;
  logic [ALUC_W-1:0]   dec_alu;
  logic                dec_valid;
  logic                timeout_hit;

  // The decoder sees the live funct only for the DECODE legality check; every
  // later state uses the latched copy, so func_in never reaches an output.
  assign dec_funct = (state_q == ST_DECODE) ? func_in : func_q;

  alu_funct_decoder #(
    .FUNCT_W (FUNCT_W),
    .ALUC_W  (ALUC_W)
  ) u_funct_dec (
    .funct_i     (dec_funct),
    .alu_cntrl_o (dec_alu),
    .valid_o     (dec_valid)
  );

  // A ready in the last allowed wait cycle takes priority over the timeout.
  assign timeout_hit = (WAIT_MAX != 0) && !mem_ready && (wait_cnt_q == WAIT_LAST);

  // Next-state, trap cause and retire decision
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    retire_d     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (op_in == OP_LW || op_in == OP_SW) begin
          state_d = ST_MEM_ADDR;
        end else if (op_in == OP_RTYPE) begin
          if (func_in == FN_NOP) begin
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end else if (dec_valid) begin
            state_d = ST_EXECUTE;
          end else begin
            state_d      = ST_TRAP;
            trap_cause_d = TRAP_ILLEGAL;
          end
        end else if (op_in == OP_BEQ) begin
          state_d = ST_BRANCH;
        end else if (op_in == OP_J) begin
          state_d = ST_JUMP;
        end else if (op_in == OP_ADDI) begin
          state_d = ST_ADDI_EX;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end
      end
      ST_MEM_ADDR: state_d = (op_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (timeout_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_MEM_WRITE: begin
        if (mem_ready) begin
          state_d  = ST_FETCH;
          retire_d = 1'b1;
        end else if (timeout_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_EXECUTE: state_d = ST_R_WB;
      ST_ADDI_EX: state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait counter restarts on every entry to a wait state.
  always_comb begin
    wait_cnt_d = '0;
    if (is_wait_state(state_q) && (state_d == state_q)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      func_q        <= '0;
      wait_cnt_q    <= '0;
      trap_cause_q  <= TRAP_NONE;
      retire_q      <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
      retire_q     <= retire_d;
      if (retire_d) begin
        retired_cnt_q <= retired_cnt_q + CNT_W'(1);
      end
      if (state_q == ST_DECODE) begin
        op_q   <= op_in;
        func_q <= func_in;
      end
    end
  end

  // Datapath controls decoded from the registered state
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_cntrl     = ALU_NOP;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    trap          = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_cntrl = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_cntrl = ALU_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cntrl = ALU_ADD;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_cntrl = dec_alu;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_cntrl = dec_alu;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_cntrl     = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
        alu_cntrl = ALU_ADD;
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause  = trap_cause_q;
  assign retire      = retire_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam int TB_WAIT_MAX = 4;
  localparam int TB_CNT_W    = 2;
  localparam int CNT_MOD     = 1 << TB_CNT_W;

  localparam int K_NOP  = 0;
  localparam int K_R    = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_BEQ  = 4;
  localparam int K_J    = 5;
  localparam int K_ADDI = 6;
  localparam int K_ILL  = 7;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_cntrl;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       trap;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic rdy;
  } step_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [5:0]          op_in = '0;
  logic [5:0]          func_in = '0;
  logic                mem_ready = 1'b0;
  logic                mem_read, mem_write, i_or_d, ir_write;
  logic                pc_write, pc_write_cond;
  logic [1:0]          pc_source;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [3:0]          alu_cntrl;
  logic                reg_write, reg_dst, mem_to_reg;
  logic                trap;
  logic [1:0]          trap_cause;
  logic                retire;
  logic [TB_CNT_W-1:0] retired_cnt;
  ctl_t                obs;

  int      n_checks = 0;
  int      n_pass = 0;
  logic    pending = 1'b0;
  int      cnt = 0;
  int      dec_idx = -1;
  step_t   steps[$];
  logic [5:0] fn_list [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OP_W     (6),
    .FUNCT_W  (6),
    .ALUC_W   (4),
    .WAIT_MAX (TB_WAIT_MAX),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_in         (op_in),
    .func_in       (func_in),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_cntrl     (alu_cntrl),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .retire        (retire),
    .retired_cnt   (retired_cnt)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, alu_cntrl, reg_write, reg_dst, mem_to_reg, trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic ctl_t base_ctl();
    ctl_t c;
    c = '0;
    c.alu_cntrl = 4'b1111;
    return c;
  endfunction

  function automatic ctl_t fetch_ctl(input logic rdy);
    ctl_t c;
    c = base_ctl();
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.alu_cntrl = 4'b1000;
    c.ir_write  = rdy;
    c.pc_write  = rdy;
    return c;
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b000000) return K_NOP;
        for (int i = 0; i < 5; i++) if (fn == fn_list[i]) return K_R;
        return K_ILL;
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b001000: return K_ADDI;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1000;
      6'b100010: return 4'b0001;
      6'b100100: return 4'b0010;
      6'b100101: return 4'b0101;
      6'b101010: return 4'b0100;
      default:   return 4'b1111;
    endcase
  endfunction

  task automatic push(input ctl_t c, input logic rdy);
    step_t s;
    s.c = c;
    s.rdy = rdy;
    steps.push_back(s);
  endtask

  // Expected per-cycle control vectors for one instruction, straight from the step table.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw);
    ctl_t c;
    int k;
    k = kind_of(op, fn);
    steps.delete();
    for (int i = 0; i < fw; i++) push(fetch_ctl(1'b0), 1'b0);
    push(fetch_ctl(1'b1), 1'b1);
    c = base_ctl(); c.alu_src_b = 2'b11; c.alu_cntrl = 4'b1000;
    push(c, 1'($urandom));
    dec_idx = fw + 1;
    if (k == K_LW || k == K_SW) begin
      c = base_ctl(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_cntrl = 4'b1000;
      push(c, 1'($urandom));
      c = base_ctl(); c.i_or_d = 1'b1;
      if (k == K_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
      for (int i = 0; i < dw; i++) push(c, 1'b0);
      push(c, 1'b1);
      if (k == K_LW) begin
        c = base_ctl(); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
        push(c, 1'($urandom));
      end
    end else if (k == K_R) begin
      c = base_ctl(); c.alu_src_a = 1'b1; c.alu_cntrl = alu_of(fn);
      push(c, 1'($urandom));
      c = base_ctl(); c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_cntrl = alu_of(fn);
      push(c, 1'($urandom));
    end else if (k == K_BEQ) begin
      c = base_ctl(); c.alu_src_a = 1'b1; c.alu_cntrl = 4'b0001;
      c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      push(c, 1'($urandom));
    end else if (k == K_J) begin
      c = base_ctl(); c.pc_write = 1'b1; c.pc_source = 2'b10;
      push(c, 1'($urandom));
    end else if (k == K_ADDI) begin
      c = base_ctl(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_cntrl = 4'b1000;
      push(c, 1'($urandom));
      c = base_ctl(); c.reg_write = 1'b1; c.alu_cntrl = 4'b1000;
      push(c, 1'($urandom));
    end
  endtask

  task automatic run_steps(input int limit);
    for (int i = 0; i < limit; i++) begin
      mem_ready = steps[i].rdy;
      #1;
      check($sformatf("ctl[%0d]", i), 32'(obs), 32'(steps[i].c));
      check($sformatf("retire[%0d]", i), 32'(retire), 32'(pending));
      check($sformatf("retired_cnt[%0d]", i), 32'(retired_cnt), cnt);
      check($sformatf("trap_cause[%0d]", i), 32'(trap_cause), 0);
      pending = 1'b0;
      @(posedge clk); #1;
      // After DECODE the IR fields are scrambled: later steps must use the latched copy.
      if (i == dec_idx) begin
        op_in   = 6'($urandom);
        func_in = 6'($urandom);
      end
    end
  endtask

  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw);
    op_in   = op;
    func_in = fn;
    build(op, fn, fw, dw);
    run_steps(steps.size());
    if (kind_of(op, fn) != K_ILL) begin
      pending = 1'b1;
      cnt = (cnt + 1) % CNT_MOD;
    end
  endtask

  task automatic check_trap(input logic [1:0] cause, input int n);
    ctl_t c;
    c = base_ctl();
    c.trap = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      #1;
      check("trap_ctl", 32'(obs), 32'(c));
      check("trap_cause", 32'(trap_cause), 32'(cause));
      check("trap_retire", 32'(retire), 32'(pending));
      pending = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    check("rst_ctl", 32'(obs), 32'(base_ctl()));
    check("rst_retire", 32'(retire), 0);
    check("rst_cnt", 32'(retired_cnt), 0);
    check("rst_cause", 32'(trap_cause), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("idle_ctl", 32'(obs), 32'(base_ctl()));
    @(posedge clk); #1;
    pending = 1'b0;
    cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int k;

    do_reset();

    // Directed: SLT, LW with 3 data waits, SW, BEQ, J, ADDI
    exec_instr(6'b000000, 6'b101010, 0, 0);
    exec_instr(6'b100011, 6'($urandom), 0, 3);
    exec_instr(6'b101011, 6'($urandom), 1, 2);
    exec_instr(6'b000100, 6'($urandom), 0, 0);
    exec_instr(6'b000010, 6'($urandom), 0, 0);
    exec_instr(6'b001000, 6'($urandom), 2, 0);

    // Counter wrap with a 2-bit counter: 5 NOPs from reset leave 1
    do_reset();
    for (int i = 0; i < 5; i++) exec_instr(6'b000000, 6'b000000, 0, 0);
    check("wrap_cnt", 32'(retired_cnt), 1);

    // Random legal instruction stream with random wait states
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 6);
      fn = 6'($urandom);
      case (k)
        0: begin op = 6'b000000; fn = 6'b000000; end
        1: begin op = 6'b000000; fn = fn_list[$urandom_range(0, 4)]; end
        2: op = 6'b100011;
        3: op = 6'b101011;
        4: op = 6'b000100;
        5: op = 6'b000010;
        default: op = 6'b001000;
      endcase
      exec_instr(op, fn, $urandom_range(0, TB_WAIT_MAX - 1), $urandom_range(0, TB_WAIT_MAX - 1));
    end

    // Ready on the last allowed wait cycle: no trap
    exec_instr(6'b000000, 6'b000000, TB_WAIT_MAX - 1, 0);
    exec_instr(6'b101011, 6'($urandom), 0, TB_WAIT_MAX - 1);

    // Reset in the middle of a load
    op_in = 6'b100011;
    build(6'b100011, 6'($urandom), 0, 3);
    run_steps(4);
    do_reset();

    // Illegal opcode
    exec_instr(6'b111111, 6'($urandom), 0, 0);
    check_trap(2'b01, 100);
    do_reset();

    // Illegal funct
    exec_instr(6'b000000, 6'b000111, 1, 0);
    check_trap(2'b01, 100);
    do_reset();

    // Fetch timeout
    steps.delete();
    for (int i = 0; i < TB_WAIT_MAX; i++) push(fetch_ctl(1'b0), 1'b0);
    dec_idx = -1;
    run_steps(TB_WAIT_MAX);
    check_trap(2'b10, 20);

    // Data-phase timeout on a load
    do_reset();
    op_in = 6'b100011;
    build(6'b100011, 6'($urandom), 0, TB_WAIT_MAX);
    run_steps(3 + TB_WAIT_MAX);
    check_trap(2'b10, 10);

    do_reset();
    exec_instr(6'b000100, 6'($urandom), 0, 0);
    exec_instr(6'b000000, 6'b100000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
